// File: rtl/load_store_unit.sv
// Load/store unit over a 4 KiB word-organised scratch memory.
// Stores complete when the request is accepted. Loads return one cycle later through a registered rdata.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        ext_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic {IDLE, RD} state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] mem [1024];

  logic        accept;
  logic        bad;
  logic        do_store;
  logic        do_load;
  logic [3:0]  be;
  logic [31:0] wlanes;

  logic [9:0]  ld_idx;
  logic [1:0]  ld_off;
  logic [1:0]  ld_size;
  logic        ld_ext;
  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  assign ready = (state == IDLE);

  // Classify the incoming request and build the store byte enables and lane data
  always_comb begin
    bad      = 1'b0;
    be       = 4'b0000;
    wlanes   = wdata;
    case (size)
      2'b00: begin
        bad = (addr[1:0] != 2'b00);
        be  = 4'b1111;
      end
      2'b01: begin
        bad    = addr[0];
        be     = addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {wdata[15:0], wdata[15:0]};
      end
      2'b10: begin
        be     = 4'b0001 << addr[1:0];
        wlanes = {4{wdata[7:0]}};
      end
      default: bad = 1'b1;
    endcase
    if (|addr[31:12])
      bad = 1'b1;
    accept   = req & ready;
    do_store = accept & wr & ~bad;
    do_load  = accept & ~wr & ~bad;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // A valid load moves to RD. RD always returns to IDLE after its single cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (do_load) next_state = RD;
      RD:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture the load parameters at acceptance so later input changes cannot disturb the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_idx  <= '0;
      ld_off  <= '0;
      ld_size <= '0;
      ld_ext  <= 1'b0;
    end else if (do_load) begin
      ld_idx  <= addr[11:2];
      ld_off  <= addr[1:0];
      ld_size <= size;
      ld_ext  <= ext_op;
    end
  end

  // Memory array. Reset clears every word. Stores write only their enabled byte lanes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= '0;
    end else if (do_store) begin
      for (int k = 0; k < 4; k++)
        if (be[k])
          mem[addr[11:2]][8*k +: 8] <= wlanes[8*k +: 8];
    end
  end

  // Select the addressed byte or half from the captured word and extend it to 32 bits
  always_comb begin
    ld_word = mem[ld_idx];
    ld_byte = ld_word[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_size)
      2'b01:   ld_result = ld_ext ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      2'b10:   ld_result = ld_ext ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      default: ld_result = ld_word;
    endcase
  end

  // Response registers. rvalid and err are single-cycle pulses. rdata holds its value between loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= (state == RD);
      err    <= accept & bad;
      if (state == RD)
        rdata <= ld_result;
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 The ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only while ready=1.
- wr  in  1  1=store, 0=load.
- size  in  2  00=word, 01=half, 10=byte, 11=reserved.
- ext_op  in  1  load extension: 0=sign-extend, 1=zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data; the low 8/16/32 bits are used according to size.
- ready  out  1  1=able to accept req this cycle.
- rvalid  out  1  one-cycle pulse; rdata is valid.
- rdata  out  32  extended load result.
- err  out  1  one-cycle pulse; rejected access.

Function
REQ-003 Storage SHALL be 1024 x 32-bit words, indexed by addr[11:2], little-endian; byte lane k holds bits [8k+7:8k].
REQ-004 A request SHALL be accepted on a rising edge where req=1 and ready=1; req while ready=0 SHALL be ignored with no side effects.
REQ-005 State machine SHALL be IDLE -> RD -> IDLE; only IDLE has ready=1.
REQ-006 Accepted valid store: memory SHALL update at the accepting edge; state stays IDLE; no rvalid; back-to-back stores every cycle SHALL be supported.
REQ-007 Accepted valid load: state SHALL go IDLE->RD at the accepting edge N; at edge N+1 rdata SHALL be registered, rvalid SHALL be 1 for exactly one cycle, and state SHALL return to IDLE (ready=1 in the same cycle as rvalid).
REQ-008 Store byte SHALL write wdata[7:0] into lane addr[1:0] only; store half SHALL write wdata[15:0] into lanes {addr[1],0} and {addr[1],1} only; store word SHALL write all lanes; untouched lanes SHALL keep their value.
REQ-009 Load byte SHALL select lane addr[1:0]; load half SHALL select half addr[1].
REQ-010 The selected 8/16 bits SHALL be widened to 32 by replicating their MSB (ext_op=0) or by zeros (ext_op=1).
REQ-011 Load word SHALL ignore ext_op.
REQ-012 The load address, size and ext_op SHALL be captured at the accepting edge; later input changes SHALL NOT affect the result.
REQ-013 An access SHALL be rejected if size=11, or if size=00 and addr[1:0]!=0, or if size=01 and addr[0]!=0, or if addr>=32'h0000_1000.
REQ-014 For a rejected access: err SHALL be 1 for exactly the cycle after the accepting edge; memory SHALL be unchanged; rvalid SHALL stay 0; state SHALL stay IDLE.
REQ-015 rdata SHALL hold its last value while rvalid=0.
REQ-016 A store accepted in the cycle rvalid=1 SHALL NOT alter the already-registered rdata.
REQ-017 A load of a word stored at an earlier edge SHALL return the new data; there is no read-during-write hazard because the store completes at acceptance.

Reset
REQ-018 While reset=1, regardless of clk: state SHALL be IDLE, ready=1, rvalid=0, err=0, rdata=32'h0, and all memory words SHALL be 32'h0.
REQ-019 Reset asserted while in RD SHALL abort the pending load; no rvalid SHALL follow deassertion.
REQ-020 The first request SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-021 After reset, load word at 0x0 -> rvalid one cycle after acceptance, rdata=32'h0000_0000.
REQ-022 Store word 0x8000_80F0 at 0x10, then load byte 0x10 with ext_op=0 -> 0xFFFF_FFF0; ext_op=1 -> 0x0000_00F0; load half 0x12 with ext_op=0 -> 0xFFFF_8000.
REQ-023 Store byte 0xAB at 0x21 over a word 0x1122_3344 at 0x20 -> load word 0x20 returns 0x1122_AB44.
REQ-024 Load word at 0x6, load half at 0x3, size=11, and store at 0x1000 -> each produces an err pulse; memory unchanged; no rvalid.
REQ-025 Load accepted, req held high in RD with a store -> store ignored (memory unchanged); reset pulsed in RD -> rvalid stays 0 and rdata=0.
